// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing IF/ID/EX/MEM/WB over a shared datapath,
// with a bounded wait on MIO_ready for every memory access.
module mcpu_ctrl #(
    parameter int WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       MIO_ready,
    input  logic [5:0] OPcode,
    input  logic [5:0] Fun,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       mem_w,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       SignExt,
    output logic [1:0] PCSource,
    output logic [2:0] ALU_Control,
    output logic       CPU_MIO,
    output logic       illegal_inst,
    output logic       mio_timeout,
    output logic [4:0] state_out
);

    typedef enum logic [4:0] {
        S_IF  = 5'd0,  S_ID  = 5'd1,  S_MA  = 5'd2,  S_MRD = 5'd3,
        S_WBL = 5'd4,  S_MWR = 5'd5,  S_EXR = 5'd6,  S_WBR = 5'd7,
        S_BR  = 5'd8,  S_J   = 5'd9,  S_EXI = 5'd10, S_WBI = 5'd11,
        S_JAL = 5'd12, S_JR  = 5'd13
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
    localparam bit         WAIT_EN   = (WAIT_MAX != 0);

    state_t     state_q, state_d, dec_state;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       op_alt_q, op_alt_d;
    logic       mem_wait, timeout_hit, illegal, r_funct_ok;

    assign r_funct_ok  = Fun inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    assign mem_wait    = (state_q == S_IF || state_q == S_MRD || state_q == S_MWR) && !MIO_ready;
    assign timeout_hit = WAIT_EN && mem_wait && (wait_cnt_q == WAIT_LAST);
    assign state_out   = state_q;

    // op_alt captures sw-vs-lw and bne-vs-beq in ID so later states need not re-read the IR
    always_comb begin
        state_d  = state_q;
        op_alt_d = op_alt_q;
        illegal  = 1'b0;
        case (state_q)
            S_IF:  if (MIO_ready) state_d = S_ID;
            S_ID: begin
                op_alt_d = (OPcode == 6'h2B) || (OPcode == 6'h05);
                case (OPcode)
                    6'h23, 6'h2B: state_d = S_MA;
                    6'h00: begin
                        if (Fun == 6'h08) begin
                            state_d = S_JR;
                        end else if (r_funct_ok) begin
                            state_d = S_EXR;
                        end else begin
                            state_d = S_IF;
                            illegal = 1'b1;
                        end
                    end
                    6'h04, 6'h05: state_d = S_BR;
                    6'h02: state_d = S_J;
                    6'h03: state_d = S_JAL;
                    6'h08, 6'h0C, 6'h0D, 6'h0A: state_d = S_EXI;
                    default: begin
                        state_d = S_IF;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MA:  state_d = op_alt_q ? S_MWR : S_MRD;
            S_MRD: if (MIO_ready) state_d = S_WBL;
            S_MWR: if (MIO_ready) state_d = S_IF;
            S_EXR: state_d = S_WBR;
            S_EXI: state_d = S_WBI;
            default: state_d = S_IF;
        endcase
        if (timeout_hit) state_d = S_IF;

        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q || timeout_hit) begin
            wait_cnt_d = 8'd0;
        end else if (mem_wait && wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IF;
            wait_cnt_q <= 8'd0;
            op_alt_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            op_alt_q   <= op_alt_d;
        end
    end

    assign dec_state = reset ? state_q : S_IF;

    always_comb begin
        PCWrite      = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        mem_w        = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 2'b00;
        MemtoReg     = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        SignExt      = 1'b0;
        PCSource     = 2'b00;
        ALU_Control  = 3'b010;
        CPU_MIO      = 1'b0;
        illegal_inst = illegal;
        mio_timeout  = timeout_hit;
        case (dec_state)
            S_IF: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MIO_ready;
                PCWrite = MIO_ready;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                SignExt = 1'b1;
            end
            S_MA: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                SignExt = 1'b1;
            end
            S_MRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
            end
            S_WBL: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            S_MWR: begin
                IorD    = 1'b1;
                mem_w   = 1'b1;
                CPU_MIO = 1'b1;
            end
            S_EXR: begin
                ALUSrcA = 1'b1;
                case (Fun)
                    6'h22:   ALU_Control = 3'b110;
                    6'h24:   ALU_Control = 3'b000;
                    6'h25:   ALU_Control = 3'b001;
                    6'h26:   ALU_Control = 3'b011;
                    6'h27:   ALU_Control = 3'b100;
                    6'h2A:   ALU_Control = 3'b111;
                    default: ALU_Control = 3'b010;
                endcase
            end
            S_WBR: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            S_BR: begin
                ALUSrcA     = 1'b1;
                ALU_Control = 3'b110;
                PCSource    = 2'b01;
                PCWrite     = op_alt_q ? ~zero : zero;
            end
            S_J: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            S_JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
            end
            S_JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
            end
            S_EXI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (OPcode)
                    6'h0C:   ALU_Control = 3'b000;
                    6'h0D:   ALU_Control = 3'b001;
                    6'h0A: begin
                        ALU_Control = 3'b111;
                        SignExt     = 1'b1;
                    end
                    default: SignExt = 1'b1;
                endcase
            end
            S_WBI: RegWrite = 1'b1;
            default: ;
        endcase
        // Strobes are suppressed for the whole reset-low cycle, whatever state is still registered
        if (!reset) begin
            PCWrite      = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            MemRead      = 1'b0;
            mem_w        = 1'b0;
            CPU_MIO      = 1'b0;
            illegal_inst = 1'b0;
            mio_timeout  = 1'b0;
        end
    end

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
Multi-cycle MIPS control unit. It is a Moore FSM that sequences the shared multi-cycle datapath (PC, IR, MDR, A/B, ALUOut) through the IF/ID/EX/MEM/WB steps. It decodes the opcode and funct from the datapath IR and handshakes with the memory/IO bus through MIO_ready. It replaces the combinational single-cycle decoder in the multi-cycle CPU top.

Parameters:
WAIT_MAX, 255, max cycles a memory state waits for MIO_ready before abort; 0 = wait forever (8-bit wait counter)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
MIO_ready  in  1  memory/IO access complete this cycle
OPcode  in  6  IR[31:26]
Fun  in  6  IR[5:0]
zero  in  1  ALU zero flag, combinational, same cycle
PCWrite  out  1  load PC (branch condition already folded in)
IorD  out  1  0 = memory address is PC, 1 = ALUOut
MemRead  out  1  memory read strobe
mem_w  out  1  memory write strobe
IRWrite  out  1  load IR (and MDR)
RegWrite  out  1  register file write
RegDst  out  2  00 rt, 01 rd, 10 $31
MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
ALUSrcA  out  1  0 PC, 1 A
ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 sign-ext imm<<2
SignExt  out  1  1 sign-extend, 0 zero-extend imm
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (jr)
ALU_Control  out  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 110 sub, 111 slt
CPU_MIO  out  1  bus access request
illegal_inst  out  1  one-cycle pulse, undecodable instruction
mio_timeout  out  1  one-cycle pulse, memory wait aborted
state_out  out  5  current state code (debug)

Behaviour:
- States and codes: IF 0, ID 1, MA 2 (address calculation), MRD 3, WBL 4, MWR 5, EXR 6, WBR 7, BR 8, J 9, EXI 10, WBI 11, JAL 12, JR 13.
- Reset (reset=0 at clk edge): state <= IF and wait_cnt <= 0. While reset=0, PCWrite, IRWrite, RegWrite, MemRead, mem_w, CPU_MIO, illegal_inst and mio_timeout are forced 0. All other outputs are don't-care during reset but are driven from the IF decode.
- Outputs are decoded from state only, except for the gated terms listed below. Any signal not listed for a state is 0; ALU_Control defaults to add.
- IF: IorD=0, MemRead=1, CPU_MIO=1, ALUSrcA=0, ALUSrcB=01, add, PCSource=00. IRWrite and PCWrite equal MIO_ready. Goes to ID when MIO_ready=1, otherwise stays in IF.
- ID: ALUSrcA=0, ALUSrcB=11, SignExt=1, add (ALUOut <= branch target). Next state by opcode:
  - 23/2B -> MA
  - 00 -> EXR, except funct 08 -> JR
  - 04/05 -> BR
  - 02 -> J
  - 03 -> JAL
  - 08/0C/0D/0A -> EXI
  - anything else -> IF with illegal_inst=1. This also covers R-type funct not in {20,22,24,25,26,27,2A,08}. No state is written.
- MA: ALUSrcA=1, ALUSrcB=10, SignExt=1, add. Goes to MRD for lw, MWR for sw.
- MRD: IorD=1, MemRead=1, CPU_MIO=1. Goes to WBL on MIO_ready.
- WBL: RegDst=00, MemtoReg=01, RegWrite=1. Goes to IF.
- MWR: IorD=1, mem_w=1, CPU_MIO=1. Goes to IF on MIO_ready.
- EXR: ALUSrcA=1, ALUSrcB=00. Funct to ALU: 20 add, 22 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt. Goes to WBR.
- WBR: RegDst=01, MemtoReg=00, RegWrite=1. Goes to IF.
- BR: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01. PCWrite = zero for beq, ~zero for bne. Goes to IF.
- J: PCSource=10, PCWrite=1. Goes to IF.
- JAL: PCSource=10, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1. The PC still holds PC+4 in this cycle. Goes to IF.
- JR: PCSource=11, PCWrite=1. Goes to IF.
- EXI: ALUSrcA=1, ALUSrcB=10.
  - addi: add, SignExt=1
  - andi: and, SignExt=0
  - ori: or, SignExt=0
  - slti: slt, SignExt=1
  - Goes to WBI.
- WBI: RegDst=00, MemtoReg=00, RegWrite=1. Goes to IF.
- Instruction latency in cycles, excluding wait states: lw 5, sw/R/I 4, branch/j/jal/jr 3.
- Wait counter:
  - Increments each cycle the FSM is in IF, MRD or MWR with MIO_ready=0. Clears on any state change.
  - If WAIT_MAX≠0 and wait_cnt==WAIT_MAX-1 with MIO_ready still 0, mio_timeout=1 that cycle and the next state is IF.
  - No write strobe is issued for the aborted access. An IF abort re-fetches the same PC. An MRD/MWR abort drops the instruction.
- MIO_ready=1 in the same cycle that the timeout condition is reached: ready wins and there is no timeout.
- Reset low in any state, including a wait, returns to IF on that edge. No partial write strobe is emitted in that cycle.
- OPcode/Fun are sampled only in ID and EXR/EXI. The IR is stable after IF.

Test Plan:
- Release reset with MIO_ready=1 and IR=add (000000…100000) -> state_out sequence 0,1,6,7,0. RegWrite=1 only in state 7, with RegDst=01 and ALU_Control=010 in state 6.
- lw (opcode 23) with MIO_ready held 0 for 3 cycles in MRD -> FSM stays in state 3 for 4 cycles, MemRead=1 and CPU_MIO=1 throughout. WBL follows with MemtoReg=01.
- beq, then bne, each with zero=1 -> PCWrite=1 in BR for beq and 0 for bne. PCSource=01 in both; state returns to 0 after 3 cycles.
- WAIT_MAX=4 with MIO_ready stuck 0 in IF -> mio_timeout pulses on the 4th wait cycle and state stays/returns 0. No IRWrite or PCWrite is asserted.
- Opcode 3F in ID -> illegal_inst=1 for 1 cycle and next state 0, with no RegWrite or mem_w.
- Assert reset=0 mid-MWR with mem_w high -> at the next edge state=0, and mem_w=0 throughout the reset-low cycles. jal run afterwards -> RegDst=10, MemtoReg=10, PCSource=10 in state 12.
